// File: rtl/core_bus_arbiter_if.sv
// rtl/core_bus_arbiter_if.sv - Wishbone bundle for core_bus_arbiter: packed master channels plus the single slave port
interface core_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic [NUM_MASTERS-1:0]        m_cyc;
   logic [NUM_MASTERS-1:0]        m_stb;
   logic [NUM_MASTERS-1:0]        m_we;
   logic [NUM_MASTERS*SEL_W-1:0]  m_sel;
   logic [NUM_MASTERS*ADDR_W-1:0] m_adr;
   logic [NUM_MASTERS*DATA_W-1:0] m_dat_w;
   logic [DATA_W-1:0]             m_dat_r;
   logic [NUM_MASTERS-1:0]        m_ack;
   logic [NUM_MASTERS-1:0]        m_err;
   logic [NUM_MASTERS-1:0]        m_stall;

   logic                          s_cyc;
   logic                          s_stb;
   logic                          s_we;
   logic [SEL_W-1:0]              s_sel;
   logic [ADDR_W-1:0]             s_adr;
   logic [DATA_W-1:0]             s_dat_w;
   logic [DATA_W-1:0]             s_dat_r;
   logic                          s_ack;
   logic                          s_err;
   logic                          s_stall;

   logic [NUM_MASTERS-1:0]        grant;

   // The arbiter is the master of the external bus; the slave view is its environment.
   modport master (
      input  m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w,
      input  s_dat_r, s_ack, s_err, s_stall,
      output m_dat_r, m_ack, m_err, m_stall,
      output s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w, grant
   );

   modport slave (
      output m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w,
      output s_dat_r, s_ack, s_err, s_stall,
      input  m_dat_r, m_ack, m_err, m_stall,
      input  s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w, grant
   );
endinterface

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - N-master to 1-slave pipelined Wishbone arbiter; CORE_ARB_TIMEOUT_EN adds a slave watchdog
module core_bus_arbiter #(
   parameter int NUM_MASTERS     = 2,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int ARB_MODE        = 0,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic               clk,
   input  logic               rst,
   core_bus_arbiter_if.master bus
);
   localparam int SEL_W = DATA_W / 8;
   localparam int PW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          rr_q, rr_d;
   logic [OW-1:0]          out_q, out_d;

   logic [PW-1:0] owner;
   logic [PW-1:0] winner;
   logic          found;
   logic          in_grant, owner_cyc, owner_stb, full;
   logic          issue, retire, release_grant, timeout_hit;

   assign in_grant      = (state_q == GRANT);
   assign owner_cyc     = |(bus.m_cyc & grant_q);
   assign owner_stb     = |(bus.m_stb & grant_q);
   assign full          = (out_q == OW'(MAX_OUTSTANDING));
   assign issue         = bus.s_stb & ~bus.s_stall;
   assign retire        = in_grant & (bus.s_ack | bus.s_err) & (out_q != '0);
   assign release_grant = in_grant & (~owner_cyc | timeout_hit);

   assign bus.s_cyc   = owner_cyc & ~timeout_hit;
   assign bus.s_stb   = owner_cyc & owner_stb & ~full & ~timeout_hit;
   assign bus.m_dat_r = bus.s_dat_r;
   assign bus.grant   = grant_q;

   always_comb begin
      owner = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (grant_q[i]) owner = PW'(i);
   end

   // Round-robin scans upward from the pointer; fixed priority scans from channel 0.
   always_comb begin
      int idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (ARB_MODE == 1) ? (int'(rr_q) + k) % NUM_MASTERS : k;
         if (!found && bus.m_cyc[idx]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               grant_d = NUM_MASTERS'(1) << winner;
            end
         end
         GRANT: begin
            if (release_grant) begin
               state_d = IDLE;
               grant_d = '0;
               rr_d    = (owner == PW'(NUM_MASTERS - 1)) ? '0 : owner + PW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // An abort or watchdog release forgets whatever is still in flight.
   always_comb begin
      out_d = out_q;
      if (release_grant)
         out_d = '0;
      else if (issue && !retire)
         out_d = out_q + OW'(1);
      else if (retire && !issue)
         out_d = out_q - OW'(1);
   end

   always_comb begin
      bus.m_stall = '1;
      bus.m_ack   = '0;
      bus.m_err   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            bus.m_stall[i] = bus.s_stall | full | timeout_hit;
            bus.m_ack[i]   = bus.s_ack & ~bus.s_err & ~timeout_hit;
            bus.m_err[i]   = bus.s_err | timeout_hit;
         end
      end
   end

   always_comb begin
      bus.s_we    = 1'b0;
      bus.s_sel   = '0;
      bus.s_adr   = '0;
      bus.s_dat_w = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            bus.s_we    = bus.m_we[i];
            bus.s_sel   = bus.m_sel[i*SEL_W +: SEL_W];
            bus.s_adr   = bus.m_adr[i*ADDR_W +: ADDR_W];
            bus.s_dat_w = bus.m_dat_w[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef CORE_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q;

   assign timeout_hit = in_grant && (out_q != '0) && !(bus.s_ack || bus.s_err) &&
                        (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd_q <= '0;
      else if (!in_grant || (out_q == '0) || bus.s_ack || bus.s_err || timeout_hit)
         wd_q <= '0;
      else
         wd_q <= wd_q + WD_W'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         out_q   <= out_d;
      end
   end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - directed self-checking bench for core_bus_arbiter
module tb_core_bus_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   core_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bf ();
   core_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) br ();

   core_bus_arbiter #(
      .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32),
      .ARB_MODE(0), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)
   ) dut_fx (
      .clk(clk), .rst(rst), .bus(bf.master)
   );

   core_bus_arbiter #(
      .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32),
      .ARB_MODE(1), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
   ) dut_rr (
      .clk(clk), .rst(rst), .bus(br.master)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bf.m_cyc = '0; bf.m_stb = '0; bf.m_we = '0; bf.m_sel = '0; bf.m_adr = '0; bf.m_dat_w = '0;
      bf.s_dat_r = '0; bf.s_ack = 1'b0; bf.s_err = 1'b0; bf.s_stall = 1'b0;
      br.m_cyc = '0; br.m_stb = '0; br.m_we = '0; br.m_sel = '0; br.m_adr = '0; br.m_dat_w = '0;
      br.s_dat_r = '0; br.s_ack = 1'b0; br.s_err = 1'b0; br.s_stall = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bf.m_cyc = 2'b11;
      br.m_cyc = 2'b11;
      tick();
      tick();
      #1;
      checks++; if (bf.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", bf.grant); end
      checks++; if (br.grant !== 2'b00) begin errors++; $display("FAIL reset_rr_grant got %b want 00", br.grant); end
      checks++; if (bf.s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got %b want 0", bf.s_cyc); end
      checks++; if (bf.s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb got %b want 0", bf.s_stb); end
      checks++; if (bf.m_ack !== 2'b00) begin errors++; $display("FAIL reset_m_ack got %b want 00", bf.m_ack); end
      checks++; if (bf.m_err !== 2'b00) begin errors++; $display("FAIL reset_m_err got %b want 00", bf.m_err); end
      checks++; if (bf.m_stall !== 2'b11) begin errors++; $display("FAIL reset_m_stall got %b want 11", bf.m_stall); end
      bf.m_cyc = 2'b00;
      br.m_cyc = 2'b00;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fixed_priority();
      bf.m_cyc = 2'b11;
      #1;
      checks++; if (bf.grant !== 2'b00) begin errors++; $display("FAIL fx_latency got %b want 00", bf.grant); end
      tick(); #1;
      checks++; if (bf.grant !== 2'b01) begin errors++; $display("FAIL fx_first_grant got %b want 01", bf.grant); end
      checks++; if (bf.s_cyc !== 1'b1) begin errors++; $display("FAIL fx_s_cyc_on got %b want 1", bf.s_cyc); end
      checks++; if (bf.m_stall !== 2'b10) begin errors++; $display("FAIL fx_stall_loser got %b want 10", bf.m_stall); end
      tick();
      bf.m_cyc = 2'b10;
      #1;
      checks++; if (bf.s_cyc !== 1'b0) begin errors++; $display("FAIL fx_s_cyc_drop got %b want 0", bf.s_cyc); end
      checks++; if (bf.grant !== 2'b01) begin errors++; $display("FAIL fx_grant_hold got %b want 01", bf.grant); end
      tick(); #1;
      checks++; if (bf.grant !== 2'b00) begin errors++; $display("FAIL fx_idle_visit got %b want 00", bf.grant); end
      tick(); #1;
      checks++; if (bf.grant !== 2'b10) begin errors++; $display("FAIL fx_second_grant got %b want 10", bf.grant); end
      checks++; if (bf.m_stall !== 2'b01) begin errors++; $display("FAIL fx_stall_ch0 got %b want 01", bf.m_stall); end
      tick();
      bf.m_cyc = 2'b00;
      tick();
      bf.m_cyc = 2'b11;
      tick(); #1;
      checks++; if (bf.grant !== 2'b01) begin errors++; $display("FAIL fx_priority_again got %b want 01", bf.grant); end
      tick();
      bf.m_cyc = 2'b00;
      tick();
   endtask

   task automatic test_read_data();
      bf.m_cyc = 2'b10;
      tick();
      bf.m_stb   = 2'b10;
      bf.m_we    = 2'b01;
      bf.m_adr   = {32'h1000_0040, 32'h2000_0000};
      bf.m_sel   = {4'hC, 4'h3};
      bf.m_dat_w = {32'hCAFE_0001, 32'h0BAD_0000};
      #1;
      checks++; if (bf.s_stb !== 1'b1) begin errors++; $display("FAIL rd_s_stb got %b want 1", bf.s_stb); end
      checks++; if (bf.s_adr !== 32'h1000_0040) begin errors++; $display("FAIL rd_s_adr got %h want 10000040", bf.s_adr); end
      checks++; if (bf.s_we !== 1'b0) begin errors++; $display("FAIL rd_s_we got %b want 0", bf.s_we); end
      checks++; if (bf.s_sel !== 4'hC) begin errors++; $display("FAIL rd_s_sel got %h want c", bf.s_sel); end
      checks++; if (bf.s_dat_w !== 32'hCAFE_0001) begin errors++; $display("FAIL rd_s_dat_w got %h want cafe0001", bf.s_dat_w); end
      tick();
      bf.m_stb   = 2'b00;
      bf.s_ack   = 1'b1;
      bf.s_dat_r = 32'hDEAD_BEEF;
      #1;
      checks++; if (bf.m_ack !== 2'b10) begin errors++; $display("FAIL rd_m_ack got %b want 10", bf.m_ack); end
      checks++; if (bf.m_dat_r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m_dat_r got %h want deadbeef", bf.m_dat_r); end
      checks++; if (bf.m_err !== 2'b00) begin errors++; $display("FAIL rd_m_err got %b want 00", bf.m_err); end
      tick();
      bf.s_ack = 1'b0;
      bf.m_stb = 2'b10;
      tick();
      bf.m_stb = 2'b00;
      bf.s_ack = 1'b1;
      bf.s_err = 1'b1;
      #1;
      checks++; if (bf.m_err !== 2'b10) begin errors++; $display("FAIL rd_err_prio_err got %b want 10", bf.m_err); end
      checks++; if (bf.m_ack !== 2'b00) begin errors++; $display("FAIL rd_err_prio_ack got %b want 00", bf.m_ack); end
      tick();
      bf.s_ack = 1'b0;
      bf.s_err = 1'b0;
      bf.m_cyc = 2'b00;
      bf.m_we  = 2'b00;
      tick();
   endtask

   task automatic test_max_outstanding();
      bf.m_cyc = 2'b01;
      tick();
      bf.m_stb = 2'b01;
      #1;
      checks++; if (bf.s_stb !== 1'b1) begin errors++; $display("FAIL mo_stb1 got %b want 1", bf.s_stb); end
      checks++; if (bf.m_stall !== 2'b10) begin errors++; $display("FAIL mo_stall1 got %b want 10", bf.m_stall); end
      tick(); #1;
      checks++; if (bf.s_stb !== 1'b1) begin errors++; $display("FAIL mo_stb2 got %b want 1", bf.s_stb); end
      tick(); #1;
      checks++; if (bf.s_stb !== 1'b0) begin errors++; $display("FAIL mo_stb3_blocked got %b want 0", bf.s_stb); end
      checks++; if (bf.m_stall !== 2'b11) begin errors++; $display("FAIL mo_stall_full got %b want 11", bf.m_stall); end
      tick();
      bf.s_ack = 1'b1;
      #1;
      checks++; if (bf.s_stb !== 1'b0) begin errors++; $display("FAIL mo_stb_ack_cycle got %b want 0", bf.s_stb); end
      checks++; if (bf.m_ack !== 2'b01) begin errors++; $display("FAIL mo_ack got %b want 01", bf.m_ack); end
      tick();
      bf.s_ack = 1'b0;
      #1;
      checks++; if (bf.s_stb !== 1'b1) begin errors++; $display("FAIL mo_stb3_issue got %b want 1", bf.s_stb); end
      checks++; if (bf.m_stall !== 2'b10) begin errors++; $display("FAIL mo_stall_free got %b want 10", bf.m_stall); end
      tick();
      bf.m_stb = 2'b00;
      bf.m_cyc = 2'b00;
      #1;
      checks++; if (bf.s_cyc !== 1'b0) begin errors++; $display("FAIL ab_s_cyc got %b want 0", bf.s_cyc); end
      tick();
      bf.s_ack = 1'b1;
      #1;
      checks++; if (bf.m_ack !== 2'b00) begin errors++; $display("FAIL ab_stray_ack1 got %b want 00", bf.m_ack); end
      tick(); #1;
      checks++; if (bf.m_ack !== 2'b00) begin errors++; $display("FAIL ab_stray_ack2 got %b want 00", bf.m_ack); end
      tick();
      bf.s_ack = 1'b0;
      bf.m_cyc = 2'b01;
      tick();
      bf.m_stb = 2'b01;
      #1;
      checks++; if (bf.s_stb !== 1'b1) begin errors++; $display("FAIL ab_clear_stb1 got %b want 1", bf.s_stb); end
      tick(); #1;
      checks++; if (bf.s_stb !== 1'b1) begin errors++; $display("FAIL ab_clear_stb2 got %b want 1", bf.s_stb); end
      tick(); #1;
      checks++; if (bf.s_stb !== 1'b0) begin errors++; $display("FAIL ab_clear_full got %b want 0", bf.s_stb); end
      bf.m_stb = 2'b00;
      bf.m_cyc = 2'b00;
      tick();
   endtask

   task automatic test_round_robin();
      logic [7:0] seq;
      logic [1:0] g;
      logic [1:0] stall_exp;
      seq = 8'b10_01_10_01;
      br.m_cyc = 2'b11;
      tick();
      for (int i = 0; i < 4; i++) begin
         g         = seq[2*i +: 2];
         stall_exp = ~g;
         #1;
         checks++; if (br.grant !== g) begin errors++; $display("FAIL rr_grant_%0d got %b want %b", i, br.grant, g); end
         checks++; if (br.m_stall !== stall_exp) begin errors++; $display("FAIL rr_stall_%0d got %b want %b", i, br.m_stall, stall_exp); end
         br.m_stb = g;
         tick();
         br.m_stb = 2'b00;
         br.s_ack = 1'b1;
         #1;
         checks++; if (br.m_ack !== g) begin errors++; $display("FAIL rr_ack_%0d got %b want %b", i, br.m_ack, g); end
         tick();
         br.s_ack = 1'b0;
         br.m_cyc = ~g;
         tick();
         br.m_cyc = 2'b11;
         tick();
      end
      br.m_cyc = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      bf.m_cyc = 2'b01;
      tick();
      bf.m_stb = 2'b01;
      tick();
      bf.m_stb = 2'b00;
      rst = 1'b1;
      #1;
      checks++; if (bf.grant !== 2'b00) begin errors++; $display("FAIL rm_grant got %b want 00", bf.grant); end
      checks++; if (bf.s_cyc !== 1'b0) begin errors++; $display("FAIL rm_s_cyc got %b want 0", bf.s_cyc); end
      checks++; if (bf.m_stall !== 2'b11) begin errors++; $display("FAIL rm_m_stall got %b want 11", bf.m_stall); end
      bf.s_ack = 1'b1;
      #1;
      checks++; if (bf.m_ack !== 2'b00) begin errors++; $display("FAIL rm_m_ack got %b want 00", bf.m_ack); end
      tick();
      rst = 1'b0;
      bf.s_ack = 1'b0;
      bf.m_cyc = 2'b00;
      tick();
   endtask

`ifdef CORE_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bf.m_cyc = 2'b01;
      tick();
      bf.m_stb = 2'b01;
      tick();
      bf.m_stb = 2'b00;
      for (int k = 1; k < 8; k++) begin
         #1;
         checks++; if (bf.m_err !== 2'b00) begin errors++; $display("FAIL to_early_err_%0d got %b want 00", k, bf.m_err); end
         checks++; if (bf.s_cyc !== 1'b1) begin errors++; $display("FAIL to_early_cyc_%0d got %b want 1", k, bf.s_cyc); end
         tick();
      end
      #1;
      checks++; if (bf.m_err !== 2'b01) begin errors++; $display("FAIL to_err_pulse got %b want 01", bf.m_err); end
      checks++; if (bf.s_cyc !== 1'b0) begin errors++; $display("FAIL to_s_cyc got %b want 0", bf.s_cyc); end
      tick(); #1;
      checks++; if (bf.m_err !== 2'b00) begin errors++; $display("FAIL to_err_one_cycle got %b want 00", bf.m_err); end
      checks++; if (bf.grant !== 2'b00) begin errors++; $display("FAIL to_idle got %b want 00", bf.grant); end
      bf.m_cyc = 2'b00;
      tick();
   endtask
`else
   task automatic test_no_timeout();
      bf.m_cyc = 2'b01;
      tick();
      bf.m_stb = 2'b01;
      tick();
      bf.m_stb = 2'b00;
      repeat (20) tick();
      #1;
      checks++; if (bf.grant !== 2'b01) begin errors++; $display("FAIL nt_grant_held got %b want 01", bf.grant); end
      checks++; if (bf.m_err !== 2'b00) begin errors++; $display("FAIL nt_no_err got %b want 00", bf.m_err); end
      checks++; if (bf.s_cyc !== 1'b1) begin errors++; $display("FAIL nt_s_cyc got %b want 1", bf.s_cyc); end
      bf.m_cyc = 2'b00;
      tick();
      tick();
   endtask
`endif

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_fixed_priority();
      test_read_data();
      test_max_outstanding();
      test_round_robin();
      test_reset_mid();
`ifdef CORE_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
